// File: rtl/switch_pkg.sv
// switch_pkg: encodings and CRC-32 constants shared by the FCS checker and
// the trash controller.
package switch_pkg;

    // Verdict published on fcs_error and consumed by the trash controller
    typedef enum logic [1:0] {
        FCS_IDLE = 2'b00,
        FCS_BUSY = 2'b01,
        FCS_GOOD = 2'b10,
        FCS_BAD  = 2'b11
    } fcs_status_t;

    // Checker FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CHECK = 2'b01,
        ST_DONE  = 2'b10
    } fcs_state_t;

    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_POLY_R  = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    localparam int          LEN_W   = 11;
    localparam logic [10:0] LEN_SAT = 11'd2047;

endpackage

// File: rtl/fcs_checker_crc32_d8.sv
// crc32_d8: one byte of reflected CRC-32 (LSB first), purely combinational.
module crc32_d8
    import switch_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] crc_w;

    // Eight serial shift/XOR steps, one per data bit, lowest bit first
    always_comb begin
        crc_w = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_w[0] ^ data[i]) begin
                crc_w = (crc_w >> 1) ^ CRC32_POLY_R;
            end else begin
                crc_w = crc_w >> 1;
            end
        end
        crc_out = crc_w;
    end

endmodule

// File: rtl/fcs_checker.sv
// fcs_checker: streaming Ethernet FCS checker feeding the trash controller.
// Optional runt/giant rejection is compiled in with `define FCS_CHECK_LEN_EN.
module fcs_checker
    import switch_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic             rx_sof,
    input  logic             rx_eof,
    input  logic [7:0]       rx_data,
    output logic [1:0]       fcs_error,
    output logic             verdict_valid,
    output logic [10:0]      frame_len,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] bad_count,
    output logic [CNT_W-1:0] abort_count
);

    fcs_state_t        state_q, state_d;
    fcs_status_t       fcs_q, fcs_d;
    logic              vv_q, vv_d;
    logic [LEN_W-1:0]  frame_len_q, frame_len_d;
    logic [31:0]       crc_q, crc_base, crc_next;
    logic [LEN_W-1:0]  len_q, len_inc;
    logic [CNT_W-1:0]  good_q, bad_q, abort_q;

    logic sof_beat, eof_beat, in_check, take_byte;
    logic complete, abort, len_ok, pass;
    fcs_status_t verdict;

    assign sof_beat  = rx_valid && rx_sof;
    assign eof_beat  = rx_valid && rx_eof;
    assign in_check  = (state_q == ST_CHECK);
    // A new sof restarts accumulation regardless of the current state
    assign take_byte = sof_beat || (rx_valid && in_check);
    // A frame completes on eof either mid-frame or as a one-beat frame
    assign complete  = eof_beat && (sof_beat || in_check);
    assign abort     = sof_beat && in_check;

    assign crc_base = sof_beat ? CRC32_INIT : crc_q;
    assign len_inc  = sof_beat ? LEN_W'(1) :
                      (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);

    crc32_d8 u_crc (
        .crc_in  (crc_base),
        .data    (rx_data),
        .crc_out (crc_next)
    );

`ifdef FCS_CHECK_LEN_EN
    assign len_ok = (len_inc >= LEN_W'(4)) &&
                    (int'(len_inc) >= MIN_LEN) && (int'(len_inc) <= MAX_LEN);
`else
    // Length limits only matter when length checking is compiled in
    logic unused_len_params;
    assign unused_len_params = (MIN_LEN > MAX_LEN);
    assign len_ok = (len_inc >= LEN_W'(4));
`endif

    assign pass    = (crc_next == CRC32_RESIDUE) && len_ok;
    assign verdict = pass ? FCS_GOOD : FCS_BAD;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: sof always (re)starts a frame, eof closes it
    always_comb begin
        state_d = state_q;
        if (sof_beat) begin
            state_d = eof_beat ? ST_DONE : ST_CHECK;
        end else if (in_check && eof_beat) begin
            state_d = ST_DONE;
        end
    end

    // Output decode: verdict is latched only when a frame completes
    always_comb begin
        fcs_d       = fcs_q;
        vv_d        = complete;
        frame_len_d = complete ? len_inc : frame_len_q;
        case (state_d)
            ST_IDLE:  fcs_d = FCS_IDLE;
            ST_CHECK: fcs_d = FCS_BUSY;
            ST_DONE:  fcs_d = complete ? verdict : fcs_q;
            default:  fcs_d = FCS_IDLE;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            fcs_q       <= FCS_IDLE;
            vv_q        <= 1'b0;
            frame_len_q <= '0;
        end else begin
            fcs_q       <= fcs_d;
            vv_q        <= vv_d;
            frame_len_q <= frame_len_d;
        end
    end

    // Running CRC and byte count of the frame in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= CRC32_INIT;
            len_q <= '0;
        end else if (take_byte) begin
            crc_q <= crc_next;
            len_q <= len_inc;
        end
    end

    // Statistics counters, free-running with wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            good_q  <= '0;
            bad_q   <= '0;
            abort_q <= '0;
        end else begin
            if (complete && pass)  good_q  <= good_q + 1'b1;
            if (complete && !pass) bad_q   <= bad_q + 1'b1;
            if (abort)             abort_q <= abort_q + 1'b1;
        end
    end

    assign fcs_error     = fcs_q;
    assign verdict_valid = vv_q;
    assign frame_len     = frame_len_q;
    assign good_count    = good_q;
    assign bad_count     = bad_q;
    assign abort_count   = abort_q;

endmodule

// File: tb/tb_fcs_checker.sv
// tb_fcs_checker: directed table-driven bench for fcs_checker.
module tb_fcs_checker;

    localparam logic [1:0] V_IDLE = 2'b00;
    localparam logic [1:0] V_BUSY = 2'b01;
    localparam logic [1:0] V_GOOD = 2'b10;
    localparam logic [1:0] V_BAD  = 2'b11;

`ifdef FCS_CHECK_LEN_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic        rx_sof = 1'b0;
    logic        rx_eof = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [1:0]  fcs_error;
    logic        verdict_valid;
    logic [10:0] frame_len;
    logic [15:0] good_count, bad_count, abort_count;

    fcs_checker #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_sof        (rx_sof),
        .rx_eof        (rx_eof),
        .rx_data       (rx_data),
        .fcs_error     (fcs_error),
        .verdict_valid (verdict_valid),
        .frame_len     (frame_len),
        .good_count    (good_count),
        .bad_count     (bad_count),
        .abort_count   (abort_count)
    );

    always #5 clk = ~clk;

    int pulses = 0;
    always @(posedge clk) begin
        if (verdict_valid) pulses <= pulses + 1;
    end

    int errors = 0;
    int checks = 0;
    int exp_good = 0, exp_bad = 0, exp_abort = 0;
    logic [7:0] frm [0:2099];

    typedef struct {
        int         len;
        int         flip;
        int         gap;
        logic [1:0] exp;
        int         exp_len;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Payload of len-4 bytes followed by its little-endian FCS; optional bit flip
    task automatic build(input int len, input int flip);
        logic [31:0] c, fcs;
        int n;
        n = (len >= 4) ? len - 4 : len;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            frm[i] = 8'(i * 13 + len + 1);
            c = crc_upd(c, frm[i]);
        end
        if (len >= 4) begin
            fcs = ~c;
            for (int k = 0; k < 4; k++) frm[n + k] = fcs[8*k +: 8];
        end
        if (flip >= 0) frm[flip][0] = ~frm[flip][0];
    endtask

    task automatic beat(input logic v, input logic s, input logic e, input logic [7:0] d);
        rx_valid = v; rx_sof = s; rx_eof = e; rx_data = d;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    endtask

    // Send frm[0..n-1]; sof on the first byte, eof on the last if requested
    task automatic send_bytes(input int n, input int gap, input bit with_eof);
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && i > 0 && (i % gap) == 0) beat(1'b0, 1'b0, 1'b0, 8'hA5);
            beat(1'b1, i == 0, with_eof && (i == n - 1), frm[i]);
            if (i == 0 && n > 1) chk("busy_after_sof", 32'(fcs_error), 32'(V_BUSY));
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_good"},  32'(good_count),  32'(exp_good));
        chk({tag, "_bad"},   32'(bad_count),   32'(exp_bad));
        chk({tag, "_abort"}, 32'(abort_count), 32'(exp_abort));
    endtask

    task automatic count(input logic [1:0] v);
        if (v == V_GOOD) exp_good++;
        else exp_bad++;
    endtask

    initial begin
        int p0;
        logic [1:0] e;

        tbl[0] = '{64,   -1, 0, V_GOOD,                     64};
        tbl[1] = '{64,   20, 0, V_BAD,                      64};
        tbl[2] = '{60,   -1, 0, LEN_EN ? V_BAD : V_GOOD,    60};
        tbl[3] = '{1518, -1, 0, V_GOOD,                     1518};
        tbl[4] = '{1519, -1, 0, LEN_EN ? V_BAD : V_GOOD,    1519};
        tbl[5] = '{3,    -1, 0, V_BAD,                      3};
        tbl[6] = '{4,    -1, 0, LEN_EN ? V_BAD : V_GOOD,    4};
        tbl[7] = '{64,   63, 0, V_BAD,                      64};
        tbl[8] = '{100,  -1, 7, V_GOOD,                     100};
        tbl[9] = '{2050, -1, 0, LEN_EN ? V_BAD : V_GOOD,    2047};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_fcs", 32'(fcs_error), 32'(V_IDLE));
        chk("rst_vv", 32'(verdict_valid), 0);
        chk("rst_len", 32'(frame_len), 0);
        chk_counts("rst");
        reset = 1'b0;
        beat(1'b0, 1'b0, 1'b0, 8'h00);

        // Table-driven single frames
        for (int t = 0; t < 10; t++) begin
            build(tbl[t].len, tbl[t].flip);
            p0 = pulses;
            send_bytes(tbl[t].len, tbl[t].gap, 1'b1);
            chk($sformatf("t%0d_vv", t), 32'(verdict_valid), 1);
            chk($sformatf("t%0d_fcs", t), 32'(fcs_error), 32'(tbl[t].exp));
            chk($sformatf("t%0d_len", t), 32'(frame_len), 32'(tbl[t].exp_len));
            count(tbl[t].exp);
            beat(1'b0, 1'b0, 1'b0, 8'h00);
            chk($sformatf("t%0d_vv_drop", t), 32'(verdict_valid), 0);
            chk($sformatf("t%0d_hold", t), 32'(fcs_error), 32'(tbl[t].exp));
            chk($sformatf("t%0d_pulses", t), 32'(pulses - p0), 1);
            chk_counts($sformatf("t%0d", t));
        end

        // Abort at byte 30 followed by a good minimum frame
        build(64, -1);
        p0 = pulses;
        send_bytes(29, 0, 1'b0);
        send_bytes(64, 0, 1'b1);
        exp_abort++; exp_good++;
        chk("abort_fcs", 32'(fcs_error), 32'(V_GOOD));
        chk("abort_len", 32'(frame_len), 64);
        beat(1'b0, 1'b0, 1'b0, 8'h00);
        chk("abort_pulses", 32'(pulses - p0), 1);
        chk_counts("abort");

        // Back-to-back good frames with no idle cycle between them
        p0 = pulses;
        build(64, -1);
        send_bytes(64, 0, 1'b1);
        chk("b2b1_vv", 32'(verdict_valid), 1);
        chk("b2b1_fcs", 32'(fcs_error), 32'(V_GOOD));
        build(70, -1);
        send_bytes(70, 0, 1'b1);
        exp_good += 2;
        chk("b2b2_vv", 32'(verdict_valid), 1);
        chk("b2b2_fcs", 32'(fcs_error), 32'(V_GOOD));
        chk("b2b2_len", 32'(frame_len), 70);
        beat(1'b0, 1'b0, 1'b0, 8'h00);
        chk("b2b_pulses", 32'(pulses - p0), 2);
        chk_counts("b2b");

        // One-byte frame: sof and eof together
        beat(1'b1, 1'b1, 1'b1, 8'h55);
        exp_bad++;
        chk("one_vv", 32'(verdict_valid), 1);
        chk("one_fcs", 32'(fcs_error), 32'(V_BAD));
        chk("one_len", 32'(frame_len), 1);

        // Stray bytes in DONE without sof are ignored
        p0 = pulses;
        beat(1'b1, 1'b0, 1'b0, 8'h11);
        beat(1'b1, 1'b0, 1'b1, 8'h22);
        beat(1'b0, 1'b0, 1'b0, 8'h00);
        chk("stray_fcs", 32'(fcs_error), 32'(V_BAD));
        chk("stray_pulses", 32'(pulses - p0), 1);
        chk("stray_len", 32'(frame_len), 1);
        chk_counts("stray");

        // Known vector: "123456789" has CRC-32 0xCBF43926
        for (int i = 0; i < 9; i++) frm[i] = 8'h31 + 8'(i);
        frm[9] = 8'h26; frm[10] = 8'h39; frm[11] = 8'hF4; frm[12] = 8'hCB;
        e = LEN_EN ? V_BAD : V_GOOD;
        send_bytes(13, 0, 1'b1);
        count(e);
        chk("kv_fcs", 32'(fcs_error), 32'(e));
        chk("kv_len", 32'(frame_len), 13);
        beat(1'b0, 1'b0, 1'b0, 8'h00);
        chk_counts("kv");

        // Reset mid-frame at byte 40, then a good frame
        build(64, -1);
        send_bytes(40, 0, 1'b0);
        reset = 1'b1;
        beat(1'b0, 1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        exp_good = 0; exp_bad = 0; exp_abort = 0;
        chk("mrst_fcs", 32'(fcs_error), 32'(V_IDLE));
        chk("mrst_vv", 32'(verdict_valid), 0);
        chk("mrst_len", 32'(frame_len), 0);
        chk_counts("mrst");
        p0 = pulses;
        send_bytes(64, 0, 1'b1);
        exp_good++;
        chk("post_fcs", 32'(fcs_error), 32'(V_GOOD));
        beat(1'b0, 1'b0, 1'b0, 8'h00);
        chk("post_pulses", 32'(pulses - p0), 1);
        chk_counts("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
